// File: rtl/phase_sequencer.sv
// Five-phase instruction sequencer: button synchronizers, INIT/IDLE/RUN/STEP control,
// registered one-hot phase strobe and a retired-instruction counter.
module phase_sequencer #(
   parameter int ICNT_W      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              exec,
   input  logic              step,
   input  logic              halt_req,
   input  logic              stall,
   output logic [2:0]        phase,
   output logic [4:0]        phase_bus,
   output logic              reset_ps,
   output logic              running,
   output logic [ICNT_W-1:0] icount
);

   typedef enum logic [1:0] {INIT, IDLE, RUN, STEP} state_t;

   state_t                   state, state_n;
   logic [2:0]               phase_n;
   logic [4:0]               phase_bus_n;
   logic [ICNT_W-1:0]        icount_n;
   logic                     stop_pending, stop_pending_n;

   logic [SYNC_STAGES-1:0]   exec_sync, step_sync;
   logic                     exec_dly, step_dly;
   logic                     exec_edge, step_edge;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         exec_sync <= '0;
         step_sync <= '0;
         exec_dly  <= 1'b0;
         step_dly  <= 1'b0;
      end else begin
         exec_sync[0] <= exec;
         step_sync[0] <= step;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            exec_sync[i] <= exec_sync[i-1];
            step_sync[i] <= step_sync[i-1];
         end
         exec_dly <= exec_sync[SYNC_STAGES-1];
         step_dly <= step_sync[SYNC_STAGES-1];
      end
   end

   assign exec_edge = exec_sync[SYNC_STAGES-1] & ~exec_dly;
   assign step_edge = step_sync[SYNC_STAGES-1] & ~step_dly;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= INIT;
         phase        <= 3'd0;
         phase_bus    <= 5'b00000;
         icount       <= '0;
         stop_pending <= 1'b0;
      end else begin
         state        <= state_n;
         phase        <= phase_n;
         phase_bus    <= phase_bus_n;
         icount       <= icount_n;
         stop_pending <= stop_pending_n;
      end
   end

   always_comb begin
      state_n        = state;
      phase_n        = phase;
      phase_bus_n    = phase_bus;
      icount_n       = icount;
      stop_pending_n = stop_pending;
      case (state)
         INIT: begin
            state_n     = IDLE;
            phase_n     = 3'd0;
            phase_bus_n = 5'b00000;
         end
         IDLE: begin
            phase_n     = 3'd0;
            phase_bus_n = 5'b00000;
            // exec has priority; a coincident step edge is simply dropped
            if (exec_edge) begin
               state_n     = RUN;
               phase_bus_n = 5'b00001;
            end else if (step_edge) begin
               state_n     = STEP;
               phase_bus_n = 5'b00001;
            end
         end
         RUN, STEP: begin
            if (state == RUN && exec_edge)
               stop_pending_n = 1'b1;
            if (!stall) begin
               if (phase == 3'd4) begin
                  icount_n = icount + 1'b1;
                  if (state == STEP || halt_req || stop_pending_n) begin
                     state_n        = IDLE;
                     phase_n        = 3'd0;
                     phase_bus_n    = 5'b00000;
                     stop_pending_n = 1'b0;
                  end else begin
                     phase_n     = 3'd0;
                     phase_bus_n = 5'b00001;
                  end
               end else begin
                  phase_n     = phase + 3'd1;
                  phase_bus_n = {phase_bus[3:0], 1'b0};
               end
            end
         end
         default: state_n = INIT;
      endcase
   end

   assign reset_ps = (state == INIT);
   assign running  = (state == RUN) || (state == STEP);

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: reset, run/stop, stall, single step, halt and wrap.
// The counter is built 8 bits wide so the wrap boundary is reachable in a short run.
module tb_phase_sequencer;

   localparam int ICNT_W = 8;

   logic              clock, reset, exec, step, halt_req, stall;
   logic [2:0]        phase;
   logic [4:0]        phase_bus;
   logic              reset_ps, running;
   logic [ICNT_W-1:0] icount;

   int n_tests = 0;
   int n_fail  = 0;
   int icnt    = 0;
   logic [4:0] seq [5];

   phase_sequencer #(.ICNT_W(ICNT_W), .SYNC_STAGES(2)) dut (
      .clock(clock), .reset(reset), .exec(exec), .step(step),
      .halt_req(halt_req), .stall(stall), .phase(phase), .phase_bus(phase_bus),
      .reset_ps(reset_ps), .running(running), .icount(icount)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      seq[0] = 5'b00010; seq[1] = 5'b00100; seq[2] = 5'b01000;
      seq[3] = 5'b10000; seq[4] = 5'b00001;
      reset = 1'b0; exec = 1'b0; step = 1'b0; halt_req = 1'b0; stall = 1'b0;
      tick(); tick();
      check("rst_phase",    32'(phase), 32'd0);
      check("rst_bus",      32'(phase_bus), 32'd0);
      check("rst_running",  32'(running), 32'd0);
      check("rst_icount",   32'(icount), 32'd0);
      check("rst_reset_ps", 32'(reset_ps), 32'd1);

      // release: one INIT cycle then IDLE
      reset = 1'b1;
      check("init_reset_ps", 32'(reset_ps), 32'd1);
      tick();
      check("idle_reset_ps", 32'(reset_ps), 32'd0);
      check("idle_bus",      32'(phase_bus), 32'd0);
      check("idle_running",  32'(running), 32'd0);

      // exec press: RUN with phase 0 two edges after first sample
      exec = 1'b1;
      tick(); tick();
      check("exec_lat_bus", 32'(phase_bus), 32'd0);
      tick();
      check("run_entry_bus",   32'(phase_bus), 32'd1);
      check("run_entry_phase", 32'(phase), 32'd0);
      check("run_entry_run",   32'(running), 32'd1);
      exec = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("run_seq_bus",   32'(phase_bus), 32'(seq[i]));
         check("run_seq_phase", 32'(phase), 32'((i + 1) % 5));
      end
      icnt = 1;
      check("run_icount1", 32'(icount), 32'(icnt));

      // stall three clocks in phase 2
      tick(); tick();
      check("pre_stall_bus", 32'(phase_bus), 32'h04);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_hold_bus", 32'(phase_bus), 32'h04);
      end
      stall = 1'b0;
      tick(); check("post_stall_p3", 32'(phase_bus), 32'h08);
      tick(); check("post_stall_p4", 32'(phase_bus), 32'h10);
      tick(); check("post_stall_wrap", 32'(phase_bus), 32'h01);
      icnt = 2;
      check("stall_icount", 32'(icount), 32'(icnt));

      // exec in phase 1: finish the instruction then IDLE
      tick(); check("stop_p1", 32'(phase_bus), 32'h02);
      exec = 1'b1;
      tick(); check("stop_p2", 32'(phase_bus), 32'h04);
      tick(); check("stop_p3", 32'(phase_bus), 32'h08);
      exec = 1'b0;
      tick(); check("stop_p4", 32'(phase_bus), 32'h10);
      check("stop_p4_run", 32'(running), 32'd1);
      tick();
      icnt = 3;
      check("stop_idle_bus", 32'(phase_bus), 32'd0);
      check("stop_idle_run", 32'(running), 32'd0);
      check("stop_icount",   32'(icount), 32'(icnt));
      tick(); tick();
      check("stop_stays_idle", 32'(running), 32'd0);

      // single step, second step during the sequence ignored
      step = 1'b1;
      tick(); tick();
      check("step_lat_bus", 32'(phase_bus), 32'd0);
      tick();
      check("step_entry_bus", 32'(phase_bus), 32'h01);
      check("step_entry_run", 32'(running), 32'd1);
      step = 1'b0;
      tick(); check("step_p1", 32'(phase_bus), 32'h02);
      step = 1'b1;
      tick(); check("step_p2", 32'(phase_bus), 32'h04);
      tick(); check("step_p3", 32'(phase_bus), 32'h08);
      tick(); check("step_p4", 32'(phase_bus), 32'h10);
      tick();
      icnt = 4;
      check("step_done_bus", 32'(phase_bus), 32'd0);
      check("step_done_run", 32'(running), 32'd0);
      check("step_icount",   32'(icount), 32'(icnt));
      tick(); tick();
      check("step_ignored_run", 32'(running), 32'd0);
      step = 1'b0;
      tick(); tick(); tick();

      // exec and step together: exec wins, so a boundary wraps instead of idling
      exec = 1'b1; step = 1'b1;
      tick(); tick(); tick();
      check("both_entry_bus", 32'(phase_bus), 32'h01);
      exec = 1'b0; step = 1'b0;
      repeat (5) tick();
      icnt = 5;
      check("both_is_run_bus", 32'(phase_bus), 32'h01);
      check("both_is_run_run", 32'(running), 32'd1);
      check("both_icount",     32'(icount), 32'(icnt));
      exec = 1'b1;
      tick(); tick();
      exec = 1'b0;
      tick(); tick(); tick();
      icnt = 6;
      check("both_stop_run",    32'(running), 32'd0);
      check("both_stop_icount", 32'(icount), 32'(icnt));

      // run up to the counter maximum, then halt with stall in phase 4
      exec = 1'b1;
      tick(); tick(); tick();
      check("wrap_entry_bus", 32'(phase_bus), 32'h01);
      exec = 1'b0;
      repeat ((255 - icnt) * 5) tick();
      check("wrap_max_icount", 32'(icount), 32'hFF);
      check("wrap_max_bus",    32'(phase_bus), 32'h01);
      repeat (4) tick();
      check("halt_p4_bus", 32'(phase_bus), 32'h10);
      halt_req = 1'b1; stall = 1'b1;
      tick();
      check("halt_stall1_bus", 32'(phase_bus), 32'h10);
      check("halt_stall1_run", 32'(running), 32'd1);
      tick();
      check("halt_stall2_bus",    32'(phase_bus), 32'h10);
      check("halt_stall2_icount", 32'(icount), 32'hFF);
      stall = 1'b0;
      tick();
      check("halt_idle_bus",   32'(phase_bus), 32'd0);
      check("halt_idle_run",   32'(running), 32'd0);
      check("halt_wrap_icount", 32'(icount), 32'd0);
      halt_req = 1'b0;

      // reset asserted in phase 3; exec held through reset release gives one edge
      exec = 1'b1;
      tick(); tick(); tick();
      check("rst2_entry_run", 32'(running), 32'd1);
      repeat (5) tick();
      check("rst2_icount1", 32'(icount), 32'd1);
      repeat (3) tick();
      check("rst2_p3_bus", 32'(phase_bus), 32'h08);
      #2 reset = 1'b0;
      #1;
      check("async_rst_bus",      32'(phase_bus), 32'd0);
      check("async_rst_icount",   32'(icount), 32'd0);
      check("async_rst_phase",    32'(phase), 32'd0);
      check("async_rst_running",  32'(running), 32'd0);
      check("async_rst_reset_ps", 32'(reset_ps), 32'd1);
      tick();
      reset = 1'b1;
      check("rst2_init_reset_ps", 32'(reset_ps), 32'd1);
      tick();
      check("rst2_idle_reset_ps", 32'(reset_ps), 32'd0);
      check("rst2_idle_run",      32'(running), 32'd0);
      tick();
      check("held_exec_wait_run", 32'(running), 32'd0);
      tick();
      check("held_exec_run", 32'(running), 32'd1);
      check("held_exec_bus", 32'(phase_bus), 32'h01);
      exec = 1'b0;
      tick();
      check("held_exec_p1", 32'(phase_bus), 32'h02);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 The block SHALL have parameter ICNT_W, default 16, giving the width of the retired-instruction counter.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the number of synchronizer flops on exec and step.
REQ-003 clock  in  1  single system clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 exec  in  1  asynchronous run/stop button; each rising edge toggles run.
REQ-006 step  in  1  asynchronous single-step button; each rising edge runs one instruction when idle.
REQ-007 halt_req  in  1  synchronous halt request from the datapath; sampled only at the end of phase 4.
REQ-008 stall  in  1  synchronous stall from the datapath; holds the current phase while high.
REQ-009 phase  out  3  current phase index, 0..4.
REQ-010 phase_bus  out  5  one-hot phase strobe; bit n is high while phase==n.
REQ-011 reset_ps  out  1  active-high datapath/register-file clear.
REQ-012 running  out  1  high in RUN or STEP.
REQ-013 icount  out  ICNT_W  retired-instruction counter.

Function
REQ-014 exec and step SHALL each pass through a SYNC_STAGES-flop synchronizer, then one edge-detect flop; the edge pulse is sync_out & ~delayed.
REQ-015 The FSM SHALL have exactly four states: INIT, IDLE, RUN and STEP.
REQ-016 INIT SHALL last one clock with reset_ps=1, then go to IDLE; reset_ps SHALL be 0 in every other state.
REQ-017 In IDLE: phase=0, phase_bus=5'b00000, running=0.
REQ-018 In IDLE, an exec edge SHALL move the FSM to RUN.
REQ-019 In IDLE, a step edge SHALL move the FSM to STEP.
REQ-020 In IDLE, if both edges occur in the same cycle, exec SHALL win and the step edge SHALL be discarded.
REQ-021 RUN and STEP SHALL enter with phase=0.
REQ-022 In RUN/STEP, phase SHALL advance by 1 each clock while stall=0, and SHALL hold while stall=1.
REQ-023 phase_bus SHALL equal the one-hot of phase in RUN/STEP, with no glitch between phases (registered output).
REQ-024 A phase-4 clock with stall=0 is an instruction boundary: icount SHALL increment by 1 and wrap modulo 2^ICNT_W (0xFFFF -> 0x0000).
REQ-025 An exec edge in RUN SHALL set stop_pending; the FSM SHALL stay in RUN until the next instruction boundary.
REQ-026 Step edges in RUN or STEP SHALL be ignored.
REQ-027 At a RUN boundary, if halt_req=1 or stop_pending=1, the FSM SHALL go to IDLE and clear stop_pending; otherwise phase SHALL wrap 4 -> 0.
REQ-028 At a STEP boundary, the FSM SHALL always go to IDLE.
REQ-029 halt_req SHALL be evaluated only at a boundary; with stall=1 in phase 4, the halt takes effect when the stalled phase completes.
REQ-030 The FSM SHALL never leave a partially executed instruction: IDLE is entered only at boundaries.
REQ-031 Latency: if exec is first sampled high at edge k (SYNC_STAGES=2), the FSM SHALL be in RUN with phase_bus=00001 after edge k+2.

Reset
REQ-032 reset=0 SHALL asynchronously force:
- state=INIT, phase=0, phase_bus=0, running=0, icount=0, reset_ps=1;
- stop_pending, synchronizer flops and edge-detect flops to 0.
REQ-033 Assertion of reset mid-instruction SHALL abort the instruction immediately, with no completion and no icount increment.
REQ-034 After reset=1, exactly one INIT cycle SHALL occur, then IDLE.
REQ-035 A button already held high at reset release SHALL produce one edge: after reset release the synchronized value goes 0 -> 1, so the edge detect fires.

Verification
REQ-036 Reset release, exec pulse at edge 10 -> reset_ps high 1 cycle; phase_bus 00001 after edge 12; sequence 01,02,04,08,10,01... each clock.
REQ-037 RUN with stall high during phase 2 for 3 clocks -> phase_bus stays 00100 for 4 clocks total; icount increments once per 5+3 clocks.
REQ-038 Second exec edge during phase 1 -> phases 2,3,4 complete, then IDLE; icount increased by exactly 1 for that instruction.
REQ-039 IDLE, step pulse -> exactly one 01..10 sequence, running=0 afterwards, icount +1; second step during the sequence ignored.
REQ-040 halt_req=1 with stall=1 in phase 4 for 2 clocks -> IDLE entered only after stall drops; icount preloaded 0xFFFF wraps to 0x0000.
REQ-041 Reset asserted in phase 3 -> phase_bus=0 and icount=0 immediately (asynchronous); then INIT, then IDLE.
